// File: rtl/cacheline_adapter.sv
// cacheline_adapter: turns 256-bit cache line reads/writebacks into 4-beat x 64-bit memory bursts
module cacheline_adapter #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address_i,
  input  logic              read_i,
  input  logic              write_i,
  input  logic [LINE_W-1:0] line_i,
  output logic [LINE_W-1:0] line_o,
  output logic              resp_o,
  output logic [ADDR_W-1:0] address_o,
  output logic              read_o,
  output logic              write_o,
  output logic [BURST_W-1:0] burst_o,
  input  logic [BURST_W-1:0] burst_i,
  input  logic              resp_i
);
  localparam int BEATS = LINE_W / BURST_W;
  localparam int CW = $clog2(BEATS);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_W / 8 - 1);
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wr_q, rd_q, rd_n;
  logic busy, last;
  assign busy = state == RD || state == WR;
  assign last = busy && resp_i && cnt == CW'(BEATS - 1);
  always_comb begin
    state_n = state == IDLE ? (write_i ? WR : read_i ? RD : IDLE) :
              state == DONE ? IDLE : last ? DONE : state;
    rd_n = rd_q;
    if (state == RD && resp_i) rd_n[cnt*BURST_W +: BURST_W] = burst_i;
  end
  // rd_q assembles beats privately; line_o only takes the finished line
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      line_o <= '0;
    end else begin
      state <= state_n;
      cnt   <= state == DONE ? '0 : busy && resp_i ? cnt + 1'b1 : cnt;
      rd_q  <= rd_n;
      if (state == IDLE && (read_i || write_i)) addr_q <= address_i & ~OFF_MASK;
      if (state == IDLE && write_i) wr_q <= line_i;
      if (state == RD && last) line_o <= rd_n;
    end
  assign read_o    = state == RD;
  assign write_o   = state == WR;
  assign resp_o    = state == DONE;
  assign address_o = addr_q;
  assign burst_o   = wr_q[cnt*BURST_W +: BURST_W];
endmodule
